// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared helpers and types for the scoreboarded register file
package rf_pkg;

    localparam int REG_ZERO = 0;

    // Address width for a register count; never below 1 so ports stay legal.
    function automatic int rf_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef enum logic [1:0] {
        SB_HOLD = 2'd0,
        SB_SET  = 2'd1,
        SB_CLR  = 2'd2
    } sb_act_t;

endpackage

// File: rtl/rf_scoreboard_regfile_if.sv
// rtl/rf_scoreboard_regfile_if.sv - decode/writeback bus into the register file
interface rf_scoreboard_regfile_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    import rf_pkg::*;

    localparam int AW = rf_aw(DEPTH);

    logic [AW-1:0]    A1;
    logic [AW-1:0]    A2;
    logic [WIDTH-1:0] RD1;
    logic [WIDTH-1:0] RD2;
    logic             RFWr;
    logic [AW-1:0]    A3;
    logic [WIDTH-1:0] WD;
    logic             iss_valid;
    logic             iss_we;
    logic [AW-1:0]    iss_rd;
    logic             stall;
    logic [AW:0]      pend_cnt;

    modport master (
        output A1, A2, RFWr, A3, WD, iss_valid, iss_we, iss_rd,
        input  RD1, RD2, stall, pend_cnt
    );

    modport slave (
        input  A1, A2, RFWr, A3, WD, iss_valid, iss_we, iss_rd,
        output RD1, RD2, stall, pend_cnt
    );

endinterface

// File: rtl/rf_busy_tbl.sv
// rtl/rf_busy_tbl.sv - per-register busy bits, writeback-adjusted busy view, pending count
module rf_busy_tbl
    import rf_pkg::*;
#(
    parameter  int DEPTH = 32,
    localparam int AW    = rf_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic             set_en,
    input  logic [AW-1:0]    set_addr,
    output logic [DEPTH-1:0] busy,
    output logic [DEPTH-1:0] eff_busy,
    output logic [AW:0]      pend_cnt
);

    sb_act_t act [DEPTH];
    logic    inc;
    logic    dec;

    // A new issue to the same register beats the writeback that clears it.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            act[i] = SB_HOLD;
            if (i != REG_ZERO) begin
                if (set_en && set_addr == AW'(i)) begin
                    act[i] = SB_SET;
                end else if (wb_en && wb_addr == AW'(i)) begin
                    act[i] = SB_CLR;
                end
            end
            eff_busy[i] = busy[i] && !(wb_en && wb_addr == AW'(i));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                case (act[i])
                    SB_SET:  busy[i] <= 1'b1;
                    SB_CLR:  busy[i] <= 1'b0;
                    default: busy[i] <= busy[i];
                endcase
            end
        end
    end

    always_comb begin
        inc = set_en && (set_addr != AW'(REG_ZERO)) && !busy[set_addr];
        dec = wb_en && (wb_addr != AW'(REG_ZERO)) && busy[wb_addr]
              && !(set_en && set_addr == wb_addr);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_cnt <= '0;
        end else begin
            case ({inc, dec})
                2'b10:   pend_cnt <= pend_cnt + 1'b1;
                2'b01:   pend_cnt <= pend_cnt - 1'b1;
                default: pend_cnt <= pend_cnt;
            endcase
        end
    end

endmodule

// File: rtl/rf_scoreboard_regfile.sv
// rtl/rf_scoreboard_regfile.sv - 2R/1W register file with bypass and hazard scoreboard; RF_TRACE_EN adds a write trace
module rf_scoreboard_regfile
    import rf_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int BYPASS = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    rf_scoreboard_regfile_if.slave  bus
);

    localparam int AW = rf_aw(DEPTH);

    logic [WIDTH-1:0] rf [DEPTH];
    logic             wr_ok;
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] eff_busy;
    logic [DEPTH-1:0] rd_busy;
    logic             set_en;
    logic             hz_a1;
    logic             hz_a2;
    logic             hz_rd;

    assign wr_ok = bus.RFWr && (bus.A3 != AW'(REG_ZERO));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else if (wr_ok) begin
            rf[bus.A3] <= bus.WD;
        end
    end

    always_comb begin
        if (bus.A1 == AW'(REG_ZERO)) begin
            bus.RD1 = '0;
        end else if ((BYPASS != 0) && bus.RFWr && bus.A3 == bus.A1) begin
            bus.RD1 = bus.WD;
        end else begin
            bus.RD1 = rf[bus.A1];
        end
    end

    always_comb begin
        if (bus.A2 == AW'(REG_ZERO)) begin
            bus.RD2 = '0;
        end else if ((BYPASS != 0) && bus.RFWr && bus.A3 == bus.A2) begin
            bus.RD2 = bus.WD;
        end else begin
            bus.RD2 = rf[bus.A2];
        end
    end

    // Without forwarding, a read only sees the writeback one cycle later, so
    // the read ports must keep waiting on the raw busy bit.
    assign rd_busy = (BYPASS != 0) ? eff_busy : busy;

    always_comb begin
        hz_a1     = (bus.A1 != AW'(REG_ZERO)) && rd_busy[bus.A1];
        hz_a2     = (bus.A2 != AW'(REG_ZERO)) && rd_busy[bus.A2];
        hz_rd     = bus.iss_we && (bus.iss_rd != AW'(REG_ZERO)) && eff_busy[bus.iss_rd];
        bus.stall = bus.iss_valid && (hz_a1 || hz_a2 || hz_rd);
        set_en    = bus.iss_valid && bus.iss_we && !bus.stall;
    end

    rf_busy_tbl #(
        .DEPTH (DEPTH)
    ) u_busy_tbl (
        .clk      (clk),
        .rstn     (rstn),
        .wb_en    (bus.RFWr),
        .wb_addr  (bus.A3),
        .set_en   (set_en),
        .set_addr (bus.iss_rd),
        .busy     (busy),
        .eff_busy (eff_busy),
        .pend_cnt (bus.pend_cnt)
    );

`ifdef RF_TRACE_EN
    always @(posedge clk) begin
        if (rstn && wr_ok) begin
            $display("R[%4X]=%8X", bus.A3, bus.WD);
            for (int i = 0; i < DEPTH; i++) begin
                $write("%8X%s", rf[i], ((i % 8) == 7) ? "\n" : " ");
            end
        end
    end
`endif

endmodule

// File: tb/tb_rf_scoreboard_regfile.sv
// tb/tb_rf_scoreboard_regfile.sv - randomized scoreboard bench for both bypass builds
module tb_rf_scoreboard_regfile;

    logic clk;
    logic rstn;

    rf_scoreboard_regfile_if #(.WIDTH(32), .DEPTH(32)) bif_b ();
    rf_scoreboard_regfile_if #(.WIDTH(32), .DEPTH(32)) bif_n ();

    rf_scoreboard_regfile #(.WIDTH(32), .DEPTH(32), .BYPASS(1)) u_byp (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bif_b)
    );

    rf_scoreboard_regfile #(.WIDTH(32), .DEPTH(32), .BYPASS(0)) u_nob (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bif_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          inst;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        stall;
        logic [5:0]  cnt;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_rf   [2][32];
    bit          m_busy [2][32];
    int          n_checks;
    int          n_errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) begin
                m_rf[k][i]   = '0;
                m_busy[k][i] = 1'b0;
            end
        end
    endtask

    function automatic logic [31:0] m_read(input int k, input logic [4:0] a, input logic wr,
                                           input logic [4:0] a3, input logic [31:0] wd);
        if (a == 0) return 32'h0;
        if (k == 0 && wr && a3 == a) return wd;
        return m_rf[k][a];
    endfunction

    function automatic bit m_wait(input int k, input logic [4:0] r, input logic wr,
                                  input logic [4:0] a3, input bit is_dest);
        if (r == 0) return 1'b0;
        if (!m_busy[k][r]) return 1'b0;
        // a same-cycle writeback resolves the wait unless it is a read without forwarding
        if (wr && a3 == r && (is_dest || k == 0)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [5:0] m_count(input int k);
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[k][i]);
        return 6'(c);
    endfunction

    task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic wr,
                         input logic [4:0] a3, input logic [31:0] wd, input logic iv,
                         input logic we, input logic [4:0] rd);
        bif_b.A1 = a1; bif_b.A2 = a2; bif_b.RFWr = wr; bif_b.A3 = a3; bif_b.WD = wd;
        bif_b.iss_valid = iv; bif_b.iss_we = we; bif_b.iss_rd = rd;
        bif_n.A1 = a1; bif_n.A2 = a2; bif_n.RFWr = wr; bif_n.A3 = a3; bif_n.WD = wd;
        bif_n.iss_valid = iv; bif_n.iss_we = we; bif_n.iss_rd = rd;
    endtask

    task automatic step(input logic [4:0] a1, input logic [4:0] a2, input logic wr,
                        input logic [4:0] a3, input logic [31:0] wd, input logic iv,
                        input logic we, input logic [4:0] rd);
        exp_t e;
        @(negedge clk);
        drive(a1, a2, wr, a3, wd, iv, we, rd);
        for (int k = 0; k < 2; k++) begin
            e.inst  = k;
            e.rd1   = m_read(k, a1, wr, a3, wd);
            e.rd2   = m_read(k, a2, wr, a3, wd);
            e.stall = iv && (m_wait(k, a1, wr, a3, 1'b0) || m_wait(k, a2, wr, a3, 1'b0)
                             || (we && m_wait(k, rd, wr, a3, 1'b1)));
            e.cnt   = m_count(k);
            q.push_back(e);
            if (wr && a3 != 0) begin
                m_rf[k][a3]   = wd;
                m_busy[k][a3] = 1'b0;
            end
            if (iv && we && !e.stall && rd != 0) m_busy[k][rd] = 1'b1;
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, " rd1_b"}, bif_b.RD1, 32'h0);
        chk({tag, " rd1_n"}, bif_n.RD1, 32'h0);
        chk({tag, " pend_b"}, 32'(bif_b.pend_cnt), 32'h0);
        chk({tag, " pend_n"}, 32'(bif_n.pend_cnt), 32'h0);
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clk);
        drive(5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
        #3 rstn = 1'b0;
        #1 reset_checks(tag);
        model_reset();
        #1 rstn = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (q.size() > 0) begin
                e = q.pop_front();
                if (e.inst == 0) begin
                    chk("rd1_byp", bif_b.RD1, e.rd1);
                    chk("rd2_byp", bif_b.RD2, e.rd2);
                    chk("stall_byp", 32'(bif_b.stall), 32'(e.stall));
                    chk("pend_byp", 32'(bif_b.pend_cnt), 32'(e.cnt));
                end else begin
                    chk("rd1_nob", bif_n.RD1, e.rd1);
                    chk("rd2_nob", bif_n.RD2, e.rd2);
                    chk("stall_nob", 32'(bif_n.stall), 32'(e.stall));
                    chk("pend_nob", 32'(bif_n.pend_cnt), 32'(e.cnt));
                end
            end
        end
    end

    initial begin : stim
        logic [4:0]  a3;
        logic [4:0]  cand[$];
        n_checks = 0;
        n_errors = 0;
        model_reset();
        drive(5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #2 reset_checks("init");
        #4 rstn = 1'b1;

        step(5, 0, 1, 5, 32'h0000_1234, 0, 0, 0);
        step(5, 0, 0, 0, 32'h0, 0, 0, 0);
        reset_pulse("rst_mid");

        step(0, 0, 1, 0, 32'hFFFF_FFFF, 1, 1, 0);
        step(0, 0, 0, 0, 32'h0, 0, 0, 0);

        step(0, 7, 1, 7, 32'hDEAD_BEEF, 0, 0, 0);
        step(0, 7, 0, 0, 32'h0, 0, 0, 0);

        step(0, 0, 0, 0, 32'h0, 1, 1, 3);
        step(3, 0, 0, 0, 32'h0, 1, 0, 0);
        step(3, 0, 1, 3, 32'h0000_0033, 1, 0, 0);
        step(0, 0, 0, 0, 32'h0, 0, 0, 0);

        step(0, 0, 0, 0, 32'h0, 1, 1, 4);
        step(0, 0, 1, 4, 32'h0000_0044, 1, 1, 4);
        step(0, 0, 0, 0, 32'h0, 0, 0, 0);
        step(0, 0, 1, 4, 32'h0000_0045, 0, 0, 0);

        for (int i = 1; i < 32; i++) step(0, 0, 0, 0, 32'h0, 1, 1, 5'(i));
        step(0, 0, 0, 0, 32'h0, 0, 0, 0);
        step(0, 0, 0, 0, 32'h0, 1, 1, 9);
        step(0, 0, 0, 0, 32'h0, 1, 1, 0);
        for (int i = 1; i < 32; i++) step(5'(i), 0, 1, 5'(i), $urandom, 0, 0, 0);
        step(0, 0, 0, 0, 32'h0, 0, 0, 0);

        for (int n = 0; n < 800; n++) begin
            cand.delete();
            for (int i = 1; i < 32; i++) if (m_busy[0][i] || m_busy[1][i]) cand.push_back(5'(i));
            a3 = 5'($urandom_range(0, 31));
            if (cand.size() > 0 && ($urandom % 3) != 0) a3 = cand[$urandom % cand.size()];
            step(5'($urandom), (($urandom % 2) != 0) ? a3 : 5'($urandom),
                 ($urandom % 2) != 0, a3, $urandom,
                 ($urandom % 4) != 0, ($urandom % 4) != 0, 5'($urandom));
            if (n == 400) reset_pulse("rst_rand");
        end

        @(negedge clk);
        @(negedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
